// File: rtl/ssp_tx_stager_pkg.sv
// Shared definitions for the SSP transmit staging buffer: drain FSM encodings,
// SSP data width and the push request bundle.
package ssp_tx_stager_pkg;

   localparam int SSP_DW = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEL  = 2'd1,
      ST_GAP  = 2'd2
   } ssp_state_e;

   typedef struct packed {
      logic              vld;
      logic [SSP_DW-1:0] dat;
   } push_req_t;

endpackage

// File: rtl/ssp_tx_stager_if.sv
// Push side (from the Wishbone slave) and SSP transmit strobes of the stager.
// The slave modport is the stager's view; master is the surrounding system.
interface ssp_tx_stager_if;
   import ssp_tx_stager_pkg::*;

   logic              push_i;
   logic [SSP_DW-1:0] push_dat_i;
   logic              push_rdy_o;
   logic              ssp_txintr_i;
   logic              ssp_psel_o;
   logic              ssp_pwrite_o;
   logic [SSP_DW-1:0] ssp_pwdata_o;

   modport slave (
      input  push_i, push_dat_i, ssp_txintr_i,
      output push_rdy_o, ssp_psel_o, ssp_pwrite_o, ssp_pwdata_o
   );

   modport master (
      output push_i, push_dat_i, ssp_txintr_i,
      input  push_rdy_o, ssp_psel_o, ssp_pwrite_o, ssp_pwdata_o
   );

endinterface

// File: rtl/ssp_tx_stager_fifo.sv
// ssp_stage_fifo: DEPTH x SSP_DW register array with wrapping pointers and an
// explicit level count, so full is level==DEPTH rather than pointer equality.
module ssp_stage_fifo
   import ssp_tx_stager_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  push_req_t         wr,
   input  logic              pop,
   output logic [SSP_DW-1:0] rd_dat,
   output logic [AW:0]       level,
   output logic              full
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [SSP_DW-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push_ok;

   // full comes from the registered level, so a pop in the same cycle
   // never rescues a push into a full buffer
   assign full    = (level == FULL_LVL);
   assign push_ok = wr.vld && !full;
   assign rd_dat  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= wr.dat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/ssp_tx_stager.sv
// SSP transmit stager: queues bytes from the bus slave and drains them as
// single-cycle PSEL/PWRITE strobes while SSPTXINTR is high. Option: STAGER_STATS_EN.
module ssp_tx_stager
   import ssp_tx_stager_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int AW         = 3,
   parameter int GAP_CYCLES = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   ssp_tx_stager_if.slave bus,
   output logic [AW:0]   level_o,
   output logic          ovf_o
`ifdef STAGER_STATS_EN
   ,
   output logic [15:0]   sent_cnt_o,
   output logic [7:0]    drop_cnt_o
`endif
);

   localparam int          GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   ssp_state_e        state;
   logic [GW-1:0]     gap_cnt;
   logic              psel_q;
   logic              pwrite_q;
   logic [SSP_DW-1:0] pwdata_q;
   push_req_t         wr_req;
   logic [SSP_DW-1:0] rd_dat;
   logic [AW:0]       level;
   logic              full;
   logic              pop;
   logic              drop;

   assign wr_req.vld = bus.push_i;
   assign wr_req.dat = bus.push_dat_i;
   assign pop        = (state == ST_SEL);
   assign drop       = bus.push_i && full;

   ssp_stage_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk    (clk_i),
      .rst    (rst_i),
      .wr     (wr_req),
      .pop    (pop),
      .rd_dat (rd_dat),
      .level  (level),
      .full   (full)
   );

   assign level_o          = level;
   assign bus.push_rdy_o   = !full;
   assign bus.ssp_psel_o   = psel_q;
   assign bus.ssp_pwrite_o = pwrite_q;
   assign bus.ssp_pwdata_o = pwdata_q;

   // txintr is only looked at in IDLE; a byte once selected always completes
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         gap_cnt  <= '0;
         psel_q   <= 1'b0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (level != '0 && bus.ssp_txintr_i) begin
                  state    <= ST_SEL;
                  psel_q   <= 1'b1;
                  pwrite_q <= 1'b1;
                  pwdata_q <= rd_dat;
               end
            end
            ST_SEL: begin
               psel_q   <= 1'b0;
               pwrite_q <= 1'b0;
               if (GAP_CYCLES == 0) begin
                  state <= ST_IDLE;
               end else begin
                  state   <= ST_GAP;
                  gap_cnt <= GAP_LOAD;
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0)
                  state <= ST_IDLE;
               else
                  gap_cnt <= gap_cnt - 1'b1;
            end
            default: begin
               state    <= ST_IDLE;
               psel_q   <= 1'b0;
               pwrite_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         ovf_o <= 1'b0;
      else if (drop)
         ovf_o <= 1'b1;
   end

`ifdef STAGER_STATS_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sent_cnt_o <= '0;
         drop_cnt_o <= '0;
      end else begin
         if (pop)
            sent_cnt_o <= sent_cnt_o + 1'b1;
         if (drop && drop_cnt_o != 8'hFF)
            drop_cnt_o <= drop_cnt_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ssp_tx_stager.sv
// Directed bench for ssp_tx_stager (DEPTH=8, GAP_CYCLES=2): reset, single byte,
// back-pressure, overflow, txintr drop, wrap with concurrency, reset mid-SEL.
module tb_ssp_tx_stager;
   import ssp_tx_stager_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] level;
   logic       ovf;
`ifdef STAGER_STATS_EN
   logic [15:0] sent_cnt;
   logic [7:0]  drop_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   logic [7:0] got [$];
   int         stamp [$];

   ssp_tx_stager_if sif ();

   ssp_tx_stager #(.DEPTH(8), .AW(3), .GAP_CYCLES(2)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .bus        (sif),
      .level_o    (level),
      .ovf_o      (ovf)
`ifdef STAGER_STATS_EN
      ,
      .sent_cnt_o (sent_cnt),
      .drop_cnt_o (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   // every strobe is captured at the edge that ends its SEL cycle
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && sif.ssp_psel_o && sif.ssp_pwrite_o) begin
         got.push_back(sif.ssp_pwdata_o);
         stamp.push_back(cyc);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      sif.push_i = 1'b0; sif.push_dat_i = 8'h00; sif.ssp_txintr_i = 1'b0;
      rst = 1'b1;
      #3;
      n_cmp++; if (sif.ssp_psel_o !== 1'b0) begin n_bad++; $display("FAIL reset_psel: got %b want 0", sif.ssp_psel_o); end
      n_cmp++; if (sif.ssp_pwrite_o !== 1'b0) begin n_bad++; $display("FAIL reset_pwrite: got %b want 0", sif.ssp_pwrite_o); end
      n_cmp++; if (sif.ssp_pwdata_o !== 8'h00) begin n_bad++; $display("FAIL reset_pwdata: got %h want 00", sif.ssp_pwdata_o); end
      n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      tick(2);
      rst = 1'b0;
      tick();
      n_cmp++; if (sif.push_rdy_o !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %b want 1", sif.push_rdy_o); end
      n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
   endtask

   task automatic test_single();
      got.delete(); stamp.delete();
      sif.ssp_txintr_i = 1'b1;
      sif.push_i = 1'b1; sif.push_dat_i = 8'hA5;
      tick();
      sif.push_i = 1'b0;
      n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL single_level1: got %0d want 1", level); end
      n_cmp++; if (sif.ssp_psel_o !== 1'b0) begin n_bad++; $display("FAIL single_early_psel: got %b want 0", sif.ssp_psel_o); end
      tick();
      n_cmp++; if ({sif.ssp_psel_o, sif.ssp_pwrite_o} !== 2'b11) begin n_bad++; $display("FAIL single_strobe: got %b want 11", {sif.ssp_psel_o, sif.ssp_pwrite_o}); end
      n_cmp++; if (sif.ssp_pwdata_o !== 8'hA5) begin n_bad++; $display("FAIL single_pwdata: got %h want a5", sif.ssp_pwdata_o); end
      tick();
      n_cmp++; if (sif.ssp_psel_o !== 1'b0) begin n_bad++; $display("FAIL single_psel_width: got %b want 0", sif.ssp_psel_o); end
      n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL single_level0: got %0d want 0", level); end
      n_cmp++; if (sif.ssp_pwdata_o !== 8'hA5) begin n_bad++; $display("FAIL single_pwdata_hold: got %h want a5", sif.ssp_pwdata_o); end
      tick(4);
      n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", got.size()); end
   endtask

   task automatic test_backpressure();
      got.delete(); stamp.delete();
      sif.ssp_txintr_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sif.push_i = 1'b1; sif.push_dat_i = 8'(i + 1);
         tick();
      end
      sif.push_i = 1'b0;
      tick(3);
      n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL bp_level: got %0d want 8", level); end
      n_cmp++; if (sif.push_rdy_o !== 1'b0) begin n_bad++; $display("FAIL bp_rdy: got %b want 0", sif.push_rdy_o); end
      n_cmp++; if (got.size() !== 0) begin n_bad++; $display("FAIL bp_no_psel: got %0d strobes want 0", got.size()); end
   endtask

   task automatic test_overflow();
      sif.push_i = 1'b1; sif.push_dat_i = 8'hFF;
      tick();
      sif.push_i = 1'b0;
      n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
      n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL ovf_level: got %0d want 8", level); end
`ifdef STAGER_STATS_EN
      n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
`endif
      sif.ssp_txintr_i = 1'b1;
      for (int t = 0; t < 60 && got.size() < 8; t++) tick();
      tick(4);
      n_cmp++; if (got.size() !== 8) begin n_bad++; $display("FAIL drain_count: got %0d want 8", got.size()); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== 8'(i + 1)) begin n_bad++; $display("FAIL drain_byte%0d: got %h want %h", i, got[i], 8'(i + 1)); end
      end
      for (int i = 1; i < 8 && i < stamp.size(); i++) begin
         n_cmp++; if (stamp[i] - stamp[i-1] !== 4) begin n_bad++; $display("FAIL drain_spacing%0d: got %0d want 4", i, stamp[i] - stamp[i-1]); end
      end
      n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
      n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL drain_level: got %0d want 0", level); end
`ifdef STAGER_STATS_EN
      n_cmp++; if (sent_cnt !== 16'd9) begin n_bad++; $display("FAIL sent_cnt: got %0d want 9", sent_cnt); end
`endif
   endtask

   task automatic test_txintr_drop();
      got.delete(); stamp.delete();
      sif.ssp_txintr_i = 1'b0;
      sif.push_i = 1'b1; sif.push_dat_i = 8'hB1; tick();
      sif.push_dat_i = 8'hB2; tick();
      sif.push_i = 1'b0;
      sif.ssp_txintr_i = 1'b1;
      tick();
      n_cmp++; if (sif.ssp_psel_o !== 1'b1) begin n_bad++; $display("FAIL drop_sel: got %b want 1", sif.ssp_psel_o); end
      sif.ssp_txintr_i = 1'b0;
      tick(6);
      n_cmp++; if (got.size() !== 1) begin n_bad++; $display("FAIL drop_sent: got %0d want 1", got.size()); end
      n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL drop_level: got %0d want 1", level); end
      sif.ssp_txintr_i = 1'b1;
      for (int t = 0; t < 20 && got.size() < 2; t++) tick();
      tick(4);
      n_cmp++; if (got.size() !== 2 || got[0] !== 8'hB1 || got[1] !== 8'hB2) begin
         n_bad++; $display("FAIL drop_order: got %0d bytes want b1,b2", got.size());
      end
   endtask

   task automatic test_wrap();
      int idx = 0;
      int max_lvl = 0;
      got.delete(); stamp.delete();
      sif.ssp_txintr_i = 1'b1;
      for (int t = 0; t < 200 && idx < 20; t++) begin
         bit acc;
         acc = sif.push_rdy_o;
         sif.push_i = acc; sif.push_dat_i = 8'(8'h10 + idx);
         tick();
         if (acc) idx++;
         if (int'(level) > max_lvl) max_lvl = int'(level);
      end
      sif.push_i = 1'b0;
      for (int t = 0; t < 120 && got.size() < 20; t++) tick();
      tick(4);
      n_cmp++; if (max_lvl > 8) begin n_bad++; $display("FAIL wrap_maxlevel: got %0d want <=8", max_lvl); end
      n_cmp++; if (max_lvl !== 8) begin n_bad++; $display("FAIL wrap_filled: got %0d want 8", max_lvl); end
      n_cmp++; if (got.size() !== 20) begin n_bad++; $display("FAIL wrap_count: got %0d want 20", got.size()); end
      for (int i = 0; i < 20 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== 8'(8'h10 + i)) begin n_bad++; $display("FAIL wrap_byte%0d: got %h want %h", i, got[i], 8'(8'h10 + i)); end
      end
   endtask

   task automatic test_reset_mid_sel();
      int t;
      got.delete(); stamp.delete();
      sif.ssp_txintr_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sif.push_i = 1'b1; sif.push_dat_i = 8'(8'hC0 + i); tick();
      end
      sif.push_i = 1'b0;
      sif.ssp_txintr_i = 1'b1;
      for (t = 0; t < 20 && sif.ssp_psel_o !== 1'b1; t++) tick();
      n_cmp++; if (sif.ssp_psel_o !== 1'b1) begin n_bad++; $display("FAIL rst_sel_reach: got %b want 1", sif.ssp_psel_o); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (sif.ssp_psel_o !== 1'b0) begin n_bad++; $display("FAIL rst_psel_async: got %b want 0", sif.ssp_psel_o); end
      tick();
      rst = 1'b0;
      tick(10);
      n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL rst_level: got %0d want 0", level); end
      n_cmp++; if (got.size() !== 0) begin n_bad++; $display("FAIL rst_no_strobes: got %0d want 0", got.size()); end
      n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_overflow();
      test_txintr_drop();
      test_wrap();
      test_reset_mid_sel();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
